// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for MIPS32 pipeline stage registers: stall encodings and NOP payload fields.
package pipe_stage_reg_pkg;

  // CTRL stall vector bit meanings
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // NOP payload field encodings used to build per-stage NOP_DATA
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP  = 3'b000;
  localparam logic [4:0] NOPRegAddr   = 5'b00000;
  localparam logic       WriteDisable = 1'b0;

  // Side-field value for an instruction not in a branch delay slot
  localparam logic NotInDelaySlot = 1'b0;

  // Canonical ID/EX-style NOP fields packed {aluop, alusel, wd, wreg}
  localparam int unsigned NOP_FIELDS_W = 17;

  function automatic logic [NOP_FIELDS_W-1:0] nop_fields();
    return {EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteDisable};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_full;

  assign w_full = (r_q == {W{1'b1}});

  // Count events, stopping at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc && !w_full) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/bubble/hold/flush handling and event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       SIDE_W   = 1,
  parameter int unsigned       STALL_W  = 6,
  parameter int unsigned       STAGE    = 2,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  // Own stall bit and the next stage's stall bit must both exist in the vector
  if (STAGE + 2 > STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be <= STALL_W-2");
  end

  localparam logic [SIDE_W-1:0] SIDE_RST = {SIDE_W{NotInDelaySlot}};

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SIDE_W-1:0] r_side;
  logic              w_s;
  logic              w_n;
  logic              w_bubble;
  logic              w_hold;

  assign w_s      = (stall[STAGE] == Stop);
  assign w_n      = (stall[STAGE+1] == Stop);
  assign w_bubble = !flush && w_s && !w_n;
  assign w_hold   = !flush && w_s && w_n;

  // Payload register: reset > flush > advance > bubble > hold
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
      r_data  <= NOP_DATA;
      r_side  <= SIDE_RST;
    end else if (!w_s) begin
      r_valid <= in_valid;
      r_data  <= in_valid ? in_data : NOP_DATA;
      r_side  <= in_side;
    end else if (!w_n) begin
      // Bubble keeps the side field so a delay-slot flag survives the stall
      r_valid <= 1'b0;
      r_data  <= NOP_DATA;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_side  = r_side;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_bubble),
    .q   (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_hold),
    .q   (hold_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a behavioural model of the stage rules.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] stall = '0;
  logic       flush = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [0:0] in_side = '0;

  logic        out_valid,  s_valid;
  logic [7:0]  out_data,   s_data;
  logic [0:0]  out_side,   s_side;
  logic [15:0] bubble_cnt, hold_cnt;
  logic [1:0]  s_bubble,   s_hold;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_side;
  int         m_bub, m_hold;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .SIDE_W(1), .STALL_W(6), .STAGE(2), .CNT_W(16),
                   .NOP_DATA(8'h00)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data), .in_side(in_side),
    .out_valid(out_valid), .out_data(out_data), .out_side(out_side),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt));

  pipe_stage_reg #(.DATA_W(8), .SIDE_W(1), .STALL_W(6), .STAGE(2), .CNT_W(2),
                   .NOP_DATA(8'h00)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data), .in_side(in_side),
    .out_valid(s_valid), .out_data(s_data), .out_side(s_side),
    .bubble_cnt(s_bubble), .hold_cnt(s_hold));

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance the model by one edge from the current inputs, then wait past the edge
  task automatic tick();
    logic s, n;
    s = stall[2];
    n = stall[3];
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_side = 1'b0; m_bub = 0; m_hold = 0;
    end else begin
      if (cnt_clr) begin
        m_bub = 0; m_hold = 0;
      end else if (!flush && s && !n) begin
        m_bub = m_bub + 1;
      end else if (!flush && s && n) begin
        m_hold = m_hold + 1;
      end
      if (flush) begin
        m_valid = 1'b0; m_data = 8'h00; m_side = 1'b0;
      end else if (!s) begin
        m_valid = in_valid; m_data = in_valid ? in_data : 8'h00; m_side = in_side[0];
      end else if (!n) begin
        m_valid = 1'b0; m_data = 8'h00;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_side = 1'b1; stall = '0;
    tick(); tick();
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
    if (out_side !== 1'b0) begin n_fail++; $display("FAIL reset_side got %0b want 0", out_side); end
    if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble got %0d want 0", bubble_cnt); end
    if (hold_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_hold got %0d want 0", hold_cnt); end
    if (s_hold !== 2'd0) begin n_fail++; $display("FAIL reset_sat_hold got %0d want 0", s_hold); end
    rst = 1'b0;
  endtask

  task automatic test_flow();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    stall = '0; in_valid = 1'b1; in_side = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      n_checks += 3;
      if (out_data !== vals[i]) begin n_fail++; $display("FAIL flow_data[%0d] got %h want %h", i, out_data, vals[i]); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flow_valid[%0d] got %0b want 1", i, out_valid); end
      if (out_side !== 1'b1) begin n_fail++; $display("FAIL flow_side[%0d] got %0b want 1", i, out_side); end
    end
  endtask

  task automatic test_bubble();
    stall = '0; in_valid = 1'b1; in_data = 8'h44; in_side = 1'b1;
    tick();
    stall = 6'b000100; in_side = 1'b0; in_data = 8'h99;
    tick(); tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL bubble_data got %h want 00", out_data); end
    if (out_side !== 1'b1) begin n_fail++; $display("FAIL bubble_side got %0b want 1", out_side); end
    if (bubble_cnt !== 16'd2) begin n_fail++; $display("FAIL bubble_cnt got %0d want 2", bubble_cnt); end
  endtask

  task automatic test_hold();
    stall = '0; in_valid = 1'b1; in_data = 8'h55; in_side = 1'b1;
    tick();
    stall = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom_range(0, 255));
      in_valid = 1'($urandom);
      tick();
      n_checks += 2;
      if (out_data !== 8'h55) begin n_fail++; $display("FAIL hold_data[%0d] got %h want 55", i, out_data); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %0b want 1", i, out_valid); end
    end
    n_checks += 1;
    if (hold_cnt !== 16'd3) begin n_fail++; $display("FAIL hold_cnt got %0d want 3", hold_cnt); end
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; stall = 6'b001100;
    tick();
    flush = 1'b0;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL flush_data got %h want 00", out_data); end
    if (out_side !== 1'b0) begin n_fail++; $display("FAIL flush_side got %0b want 0", out_side); end
    if (bubble_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_bubble got %0d want 2", bubble_cnt); end
    if (hold_cnt !== 16'd3) begin n_fail++; $display("FAIL flush_hold got %0d want 3", hold_cnt); end
  endtask

  task automatic test_saturation_clear();
    stall = '0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; stall = 6'b001100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks += 1;
      if (s_hold !== 2'(sat(i, 3))) begin n_fail++; $display("FAIL sat_hold[%0d] got %0d want %0d", i, s_hold, sat(i, 3)); end
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks += 2;
    if (s_hold !== 2'd0) begin n_fail++; $display("FAIL clr_sat_hold got %0d want 0", s_hold); end
    if (hold_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_hold got %0d want 0", hold_cnt); end
    stall = '0;
  endtask

  task automatic test_random();
    logic [5:0] st;
    for (int c = 0; c < 400; c++) begin
      st = 6'($urandom);
      if (st[3]) st[2] = 1'b1;
      stall    = st;
      rst      = ($urandom_range(0, 31) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      cnt_clr  = ($urandom_range(0, 15) == 0);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_side  = 1'($urandom);
      tick();
      n_checks += 10;
      if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, out_valid, m_valid); end
      if (out_data !== m_data) begin n_fail++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, m_data); end
      if (out_side !== m_side) begin n_fail++; $display("FAIL rnd_side c=%0d got %0b want %0b", c, out_side, m_side); end
      if (bubble_cnt !== 16'(sat(m_bub, 65535))) begin n_fail++; $display("FAIL rnd_bubble c=%0d got %0d want %0d", c, bubble_cnt, m_bub); end
      if (hold_cnt !== 16'(sat(m_hold, 65535))) begin n_fail++; $display("FAIL rnd_hold c=%0d got %0d want %0d", c, hold_cnt, m_hold); end
      if (s_valid !== m_valid) begin n_fail++; $display("FAIL rnd_s_valid c=%0d got %0b want %0b", c, s_valid, m_valid); end
      if (s_data !== m_data) begin n_fail++; $display("FAIL rnd_s_data c=%0d got %h want %h", c, s_data, m_data); end
      if (s_side !== m_side) begin n_fail++; $display("FAIL rnd_s_side c=%0d got %0b want %0b", c, s_side, m_side); end
      if (s_bubble !== 2'(sat(m_bub, 3))) begin n_fail++; $display("FAIL rnd_s_bubble c=%0d got %0d want %0d", c, s_bubble, sat(m_bub, 3)); end
      if (s_hold !== 2'(sat(m_hold, 3))) begin n_fail++; $display("FAIL rnd_s_hold c=%0d got %0d want %0d", c, s_hold, sat(m_hold, 3)); end
    end
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = '0;
  endtask

  initial begin
    m_valid = 1'b0; m_data = 8'h00; m_side = 1'b0; m_bub = 0; m_hold = 0;
    test_reset();
    test_flow();
    test_bubble();
    test_hold();
    test_flush_priority();
    test_saturation_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the in-order MIPS32 core; one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It is the generalised successor of the hand-written per-stage registers. Each cycle it captures a packed payload from the upstream stage, honours the CTRL stall vector, inserts NOP bubbles and accepts a pipeline flush. It also carries a side field, such as the delay-slot flag, that survives bubbles, and keeps saturating bubble/hold statistics counters.

## Interface
- DATA_W, 64: width of packed payload (aluop, alusel, operands, wd, wreg, link address, ...).
- SIDE_W, 1: width of side field retained across bubbles.
- STALL_W, 6: width of CTRL stall vector.
- STAGE, 2: index of this register's own stall bit; must satisfy 0 ≤ STAGE ≤ STALL_W-2 (elaboration error otherwise).
- CNT_W, 16: statistics counter width.
- NOP_DATA, 0: payload value driven for a bubble/flush (encodes NOP op, NOP reg addr, write disabled).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  CTRL stall vector; bit = 1 means stop.
- flush  in  1  discard contents (exception/branch-misprediction kill).
- cnt_clr  in  1  synchronous clear of both statistics counters.
- in_valid  in  1  upstream payload is a real instruction.
- in_data  in  DATA_W  upstream payload.
- in_side  in  SIDE_W  upstream side field.
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered payload.
- out_side  out  SIDE_W  registered side field.
- bubble_cnt  out  CNT_W  cycles in which a bubble was inserted.
- hold_cnt  out  CNT_W  cycles in which contents were held.

## Operation
- Let S = stall[STAGE] and N = stall[STAGE+1]. Actions are evaluated in strict priority each edge:
  1. rst: out_valid=0, out_data=NOP_DATA, out_side=0, both counters=0.
  2. flush: out_valid=0, out_data=NOP_DATA, out_side=0. Flush overrides any stall combination.
  3. Bubble (S=1, N=0): out_valid=0, out_data=NOP_DATA. out_side is held unchanged, deliberately, so the delay-slot flag is not lost. bubble_cnt increments.
  4. Advance (S=0): out_valid<=in_valid; out_data<=in_valid ? in_data : NOP_DATA; out_side<=in_side. This happens regardless of N. CTRL guarantees that N=1 implies S=1.
  5. Hold (S=1, N=1): all of out_* keep their values; hold_cnt increments.
- Counters saturate at all-ones and never wrap. cnt_clr forces 0 and wins over a same-cycle increment. flush does not clear the counters; only rst and cnt_clr do.
- The stall vector bits other than STAGE and STAGE+1 are ignored.

## Timing
- Latency 1 cycle, in → out. All outputs come directly from flops, with no combinational path from input to output.
- A bubble is visible on out_* at the edge after the cycle where S=1 and N=0. A held value persists for exactly as many cycles as S=N=1.
- rst asserted mid-stall or mid-flush: reset values appear after the next edge. First advance is possible on the edge after rst deasserts.
- The counter value updates on the same edge as the event it counts.

## Structure
- Shared package / defines: Stop/NoStop stall encodings, NOP payload constants (EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteDisable), NotInDelaySlot. Per-stage NOP_DATA is built from these constants at instantiation.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q), is instantiated twice.
- Payload packing and unpacking happens in the instantiating top-level, not inside this block.

## Test plan
All scenarios use DATA_W=8, SIDE_W=1, STALL_W=6, STAGE=2, NOP_DATA=0x00.
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=0x00, out_side=0, both counters 0.
- Flow: stall=0, feed 0x11, 0x22, 0x33 (valid, side=1) -> out_data shows 0x11, 0x22, 0x33 on successive edges with one-cycle lag; out_side=1.
- Bubble: load 0x44 with side=1, then stall=6'b000100 for 2 cycles -> out_valid=0, out_data=0x00, out_side stays 1, bubble_cnt=2.
- Hold: load 0x55, then stall=6'b001100 for 3 cycles -> out_data stays 0x55, out_valid=1, hold_cnt=3, in_data changes ignored.
- Flush priority: flush=1 with stall=6'b001100 while holding 0x55 -> out_valid=0, out_data=0x00, out_side=0; counters unchanged.
- Saturation/clear: CNT_W=2, 5 hold cycles -> hold_cnt=3 and stays 3. Then cnt_clr=1 together with a hold cycle -> hold_cnt=0.
